// File: rtl/riscv_pkg.sv
// Shared RISC-V immediate-format codes and the output-stage state type,
// used by both the encode (pack) side and the decode-side immediate logic.
package riscv_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_R = 3'b111;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } pack_state_e;

endpackage

// File: rtl/imm_pack_enc.sv
// Combinational immediate packer: scatters imm into the instruction fields of
// the selected format and flags values that the format cannot represent.
module imm_pack_enc
  import riscv_pkg::*;
(
  input  logic [31:0] imm,
  input  logic [2:0]  imm_src,
  input  logic [31:0] template,
  output logic [31:0] instr,
  output logic        err
);

  // A field is representable when every bit above it repeats the sign bit.
  logic is_ok;
  logic b_ok;
  logic j_ok;

  assign is_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_ok  = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign j_ok  = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

  always_comb begin
    instr = template;
    err   = 1'b0;
    case (imm_src)
      IMM_I: begin
        instr[31:20] = imm[11:0];
        err          = ~is_ok;
      end
      IMM_S: begin
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
        err          = ~is_ok;
      end
      IMM_B: begin
        instr[31]    = imm[12];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
        instr[7]     = imm[11];
        err          = ~b_ok;
      end
      IMM_J: begin
        instr[31]    = imm[20];
        instr[30:21] = imm[10:1];
        instr[20]    = imm[11];
        instr[19:12] = imm[19:12];
        err          = ~j_ok;
      end
      IMM_U: begin
        instr[31:12] = imm[31:12];
        err          = |imm[11:0];
      end
      IMM_R: err = 1'b0;
      // Unassigned codes leave the template untouched but are flagged.
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_pack.sv
// Registered immediate packer: one-entry output buffer with valid/ready on
// both sides, full-throughput when draining and loading in the same cycle.
module imm_pack
  import riscv_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_imm,
  input  logic [2:0]       in_imm_src,
  input  logic [31:0]      in_template,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clear
);

  pack_state_e      state_reg;
  logic [31:0]      instr_reg;
  logic             err_reg;
  logic [CNT_W-1:0] err_count_reg;

  logic [31:0] enc_instr;
  logic        enc_err;
  logic        xfer;
  logic        err_xfer;

  imm_pack_enc u_enc (
    .imm      (in_imm),
    .imm_src  (in_imm_src),
    .template (in_template),
    .instr    (enc_instr),
    .err      (enc_err)
  );

  assign in_ready  = (state_reg == ST_EMPTY) || out_ready;
  assign xfer      = in_valid && in_ready;
  assign err_xfer  = xfer && enc_err;
  assign out_valid = (state_reg == ST_FULL);
  assign out_instr = instr_reg;
  assign out_err   = err_reg;
  assign err_count = err_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
      instr_reg <= 32'h0;
      err_reg   <= 1'b0;
    end else if (xfer) begin
      state_reg <= ST_FULL;
      instr_reg <= enc_instr;
      err_reg   <= enc_err;
    end else if (out_ready) begin
      state_reg <= ST_EMPTY;
    end
  end

  // Clear wins over counting, but an erroneous transfer in the same cycle
  // is still recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_reg <= '0;
    end else if (err_clear) begin
      err_count_reg <= err_xfer ? CNT_W'(1) : '0;
    end else if (err_xfer && (err_count_reg != {CNT_W{1'b1}})) begin
      err_count_reg <= err_count_reg + CNT_W'(1);
    end
  end

endmodule
